// File: rtl/note_seq_pkg.sv
// Shared types for the note sequencer: FSM states, default field widths and
// the note table entry layout.
package note_seq_pkg;
  localparam int DIV_W_DFLT = 12;
  localparam int DUR_W_DFLT = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_PLAY, ST_GAP} state_e;

  typedef struct packed {
    logic [DIV_W_DFLT-1:0] div;
    logic [DUR_W_DFLT-1:0] dur;
  } entry_t;
endpackage

// File: rtl/note_sequencer_if.sv
// Table-write, playback control and tone-generator status bundle of the sequencer.
interface note_sequencer_if
  import note_seq_pkg::*;
#(
  parameter int NUM_STEPS = 16,
  parameter int DIV_W     = DIV_W_DFLT,
  parameter int DUR_W     = DUR_W_DFLT
);
  localparam int AW = $clog2(NUM_STEPS);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DIV_W-1:0] wr_divider;
  logic [DUR_W-1:0] wr_duration;
  logic             start;
  logic             stop;
  logic             loop_en;
  logic [DIV_W-1:0] divider;
  logic             pwm_en;
  logic             busy;
  logic [AW-1:0]    step_idx;
  logic             done;

  modport master (
    output wr_en, wr_addr, wr_divider, wr_duration, start, stop, loop_en,
    input  divider, pwm_en, busy, step_idx, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_divider, wr_duration, start, stop, loop_en,
    output divider, pwm_en, busy, step_idx, done
  );
endinterface

// File: rtl/note_tick_gen.sv
// Duration tick generator: counts 0..TICK_CYCLES-1 while enabled, one-cycle tick on the last count.
module note_tick_gen #(
  parameter int TICK_CYCLES = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);
  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && !clr_i && (cnt_q == CW'(TICK_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i) cnt_d = '0;
    else if (tick_o)    cnt_d = '0;
    else                cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/note_sequencer.sv
// Plays a programmable note table: each entry drives the tone divider for a number
// of ticks, followed by a silent articulation gap.
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int CLOCK_FREQ  = 40_000_000,
  parameter int TICK_HZ     = 64,
  parameter int TICK_CYCLES = CLOCK_FREQ / TICK_HZ,
  parameter int NUM_STEPS   = 16,
  parameter int DIV_W       = DIV_W_DFLT,
  parameter int DUR_W       = DUR_W_DFLT,
  parameter int GAP_TICKS   = 1
) (
  input logic             clk,
  input logic             rst_n,
  note_sequencer_if.slave bus
);
  localparam int AW    = $clog2(NUM_STEPS);
  localparam int GW    = $clog2(GAP_TICKS + 1);
  localparam int REM_W = (GW > DUR_W) ? GW : DUR_W;

  entry_t           tbl_q [NUM_STEPS];
  entry_t           ent;
  state_e           state_q, state_d;
  logic [AW-1:0]    step_q, step_d, step_idx_q, step_idx_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] divider_q, divider_d;
  logic             pwm_en_q, pwm_en_d, done_q, done_d, wrap_q, wrap_d;
  logic             run, tick;

  // Table is deliberately outside reset so a loaded tune survives a reset.
  always_ff @(posedge clk) begin
    if (bus.wr_en) tbl_q[bus.wr_addr] <= '{div: bus.wr_divider, dur: bus.wr_duration};
  end

  assign ent = tbl_q[step_q];
  assign run = (state_q == ST_PLAY) || (state_q == ST_GAP);

  note_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (run),
    .clr_i  (bus.stop),
    .tick_o (tick)
  );

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    step_idx_d = step_idx_q;
    rem_d      = rem_q;
    divider_d  = divider_q;
    pwm_en_d   = pwm_en_q;
    wrap_d     = wrap_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.start && !bus.stop) begin
        state_d = ST_LOAD;
        step_d  = '0;
        wrap_d  = 1'b0;
      end
      // Running off the last step behaves like an end marker; entry 0 never loops.
      ST_LOAD: begin
        if (wrap_q || ent.dur == '0) begin
          if (bus.loop_en && (wrap_q || step_q != '0)) begin
            step_d = '0;
            wrap_d = 1'b0;
          end else begin
            state_d  = ST_IDLE;
            pwm_en_d = 1'b0;
            done_d   = 1'b1;
          end
        end else begin
          divider_d  = ent.div;
          pwm_en_d   = (ent.div != '0);
          step_idx_d = step_q;
          rem_d      = REM_W'(ent.dur);
          state_d    = ST_PLAY;
        end
      end
      ST_PLAY, ST_GAP: if (tick) begin
        if (rem_q != REM_W'(1)) begin
          rem_d = rem_q - 1'b1;
        end else if (state_q == ST_PLAY && GAP_TICKS > 0) begin
          state_d  = ST_GAP;
          pwm_en_d = 1'b0;
          rem_d    = REM_W'(GAP_TICKS);
        end else begin
          state_d = ST_LOAD;
          step_d  = step_q + 1'b1;
          wrap_d  = (step_q == AW'(NUM_STEPS - 1));
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (bus.stop && state_q != ST_IDLE) begin
      state_d    = ST_IDLE;
      pwm_en_d   = 1'b0;
      done_d     = 1'b0;
      divider_d  = divider_q;
      step_idx_d = step_idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      step_q     <= '0;
      step_idx_q <= '0;
      rem_q      <= '0;
      divider_q  <= '0;
      pwm_en_q   <= 1'b0;
      done_q     <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      step_idx_q <= step_idx_d;
      rem_q      <= rem_d;
      divider_q  <= divider_d;
      pwm_en_q   <= pwm_en_d;
      done_q     <= done_d;
      wrap_q     <= wrap_d;
    end
  end

  assign bus.divider  = divider_q;
  assign bus.pwm_en   = pwm_en_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.step_idx = step_idx_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: a note-level timeline model predicts every output cycle.
module tb_note_sequencer;
  localparam int TC  = 10;
  localparam int GAP = 1;
  localparam int NS  = 16;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        pwm;
    logic [3:0]  idx;
    logic [11:0] div;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  note_sequencer_if #(.NUM_STEPS(NS)) bus ();

  note_sequencer #(
    .TICK_CYCLES (TC),
    .NUM_STEPS   (NS),
    .GAP_TICKS   (GAP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_div [NS];
  int   m_dur [NS];
  int   mdl_div = 0;
  int   mdl_idx = 0;
  obs_t exp_q [$];
  obs_t last_e;

  function automatic obs_t mk(bit b, bit d, bit p, int i, int v);
    obs_t o;
    o.busy = b; o.done = d; o.pwm = p; o.idx = 4'(i); o.div = 12'(v);
    return o;
  endfunction

  function automatic obs_t idle_e();
    return mk(0, 0, 0, mdl_idx, mdl_div);
  endfunction

  task automatic chk(input string tag, input obs_t e);
    obs_t o;
    o.busy = bus.busy; o.done = bus.done; o.pwm = bus.pwm_en;
    o.idx  = bus.step_idx; o.div = bus.divider;
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic wr(input int a, input int dv, input int du);
    bus.wr_en = 1'b1; bus.wr_addr = 4'(a);
    bus.wr_divider = 12'(dv); bus.wr_duration = 4'(du);
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    m_div[a] = dv; m_dur[a] = du;
  endtask

  // Timeline from the note table: a load cycle per step, then note ticks and gap ticks.
  task automatic build(input bit loop, input int limit);
    int s = 0;
    bit wrapped = 0;
    exp_q.delete();
    while (exp_q.size() < limit) begin
      exp_q.push_back(mk(1, 0, 0, mdl_idx, mdl_div));
      if (wrapped || m_dur[s] == 0) begin
        if (loop && (wrapped || s != 0)) begin
          s = 0; wrapped = 0;
        end else begin
          exp_q.push_back(mk(0, 1, 0, mdl_idx, mdl_div));
          break;
        end
      end else begin
        mdl_div = m_div[s]; mdl_idx = s;
        repeat (m_dur[s] * TC) exp_q.push_back(mk(1, 0, m_div[s] != 0, s, m_div[s]));
        repeat (GAP * TC)      exp_q.push_back(mk(1, 0, 0, s, m_div[s]));
        wrapped = (s == NS - 1);
        s = (s + 1) % NS;
      end
    end
  endtask

  task automatic run_seq(input string tag, input int n, input int start_at);
    obs_t e;
    bus.start = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.start = (i == start_at);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : idle_e();
      chk(tag, e);
      last_e = e;
    end
    bus.start = 1'b0;
  endtask

  task automatic do_stop(input string tag);
    bus.stop = 1'b1;
    @(posedge clk); #1;
    bus.stop = 1'b0;
    mdl_div = int'(last_e.div); mdl_idx = int'(last_e.idx);
    exp_q.delete();
    chk(tag, idle_e());
    repeat (3) begin
      @(posedge clk); #1;
      chk({tag, "_idle"}, idle_e());
    end
  endtask

  initial begin
    int len, n;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_divider = '0; bus.wr_duration = '0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.loop_en = 1'b0;

    // Reset, with the table cleared while reset is held
    for (int a = 0; a < NS; a++) wr(a, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset", mk(0, 0, 0, 0, 0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_release", mk(0, 0, 0, 0, 0));

    // Two-note sequence
    wr(0, 'h1A0, 2); wr(1, 'h150, 1); wr(2, 'h7, 0);
    build(0, 400);
    run_seq("two_note", 60, -1);

    // Start during PLAY is ignored
    build(0, 400);
    run_seq("start_in_play", 60, 8);

    // Rest note
    wr(0, 0, 3); wr(1, 'h55, 0);
    build(0, 400);
    run_seq("rest", 50, -1);

    // Looping two-step table, stopped mid-note
    wr(0, $urandom_range(1, 4095), 1); wr(1, $urandom_range(1, 4095), 2); wr(2, 'h3C, 0);
    bus.loop_en = 1'b1;
    build(1, 400);
    run_seq("loop", 115, -1);
    do_stop("loop_stop");
    bus.loop_en = 1'b0;

    // Full table runs off the end
    for (int a = 0; a < NS; a++) wr(a, $urandom_range(1, 4095), 1);
    build(0, 1000);
    n = exp_q.size() + 4;
    run_seq("full_table", n, -1);

    // Randomized short tunes
    for (int r = 0; r < 3; r++) begin
      len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++)
        wr(k, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 4095), $urandom_range(1, 3));
      wr(len, $urandom_range(0, 4095), 0);
      build(0, 1000);
      n = exp_q.size() + 3;
      run_seq("rand", n, -1);
    end

    // start and stop together in IDLE
    bus.start = 1'b1; bus.stop = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.stop = 1'b0;
    chk("start_stop_idle", idle_e());
    @(posedge clk); #1;
    chk("start_stop_idle2", idle_e());

    // Entry 0 as end marker with loop_en never livelocks
    wr(0, 'h123, 0);
    bus.loop_en = 1'b1;
    build(1, 400);
    run_seq("entry0_end", 5, -1);
    bus.loop_en = 1'b0;

    // Reset mid-PLAY
    wr(0, 'h2AA, 3); wr(1, 'h11, 0);
    build(0, 400);
    run_seq("pre_rst", 10, -1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    mdl_div = 0; mdl_idx = 0;
    exp_q.delete();
    chk("rst_mid_play", idle_e());
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_idle", idle_e());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
